// File: rtl/jtag_reg_ctrl.sv
// jtag_reg_ctrl: register-access controller behind ECP5 JTAG user chain 2 (ER2).
//
// Each DR scan carries one frame, sent LSB first:
//   [0] = rw (1 = write), [ADDR_W:1] = addr, [SHIFT_W-1:ADDR_W+1] = data.
// When JUPDATE is seen, the controller checks the frame. A good frame causes one
// single-cycle bus write or read on the following cycle. The next capture loads
// the status word {rd_hold, last_addr, err} into the shift register, so the host
// reads it back on its next scan.
//
// Optional feature (compile-time macro JTAG_AUTOINC_EN):
//   When the macro is defined, the all-ones address field is reserved.
//   It selects last_addr + 1, which wraps from NUM_REGS-1 back to 0.
//   This needs NUM_REGS < 2**ADDR_W.
//   When the macro is undefined, all-ones is an ordinary address and is
//   range-checked like any other.
//
// Ports:
//   JTCK       in   JTAG clock, the only clock
//   JRSTN      in   asynchronous active-low reset
//   JTDI       in   serial data in
//   JSHIFT     in   shift-DR active
//   JUPDATE    in   update-DR strobe
//   JCE2       in   chain-2 enable (capture when !JSHIFT, shift when JSHIFT)
//   JTD2       out  serial data out, always shift_reg[0]
//   bus_we     out  one-cycle write strobe
//   bus_re     out  one-cycle read strobe
//   bus_addr   out  register address, held until the next operation
//   bus_wdata  out  write data, held until the next operation
//   bus_rdata  in   read data from the bank, valid while bus_re is high
module jtag_reg_ctrl #(
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned NUM_REGS = 12
) (
    input  logic              JTCK,
    input  logic              JRSTN,
    input  logic              JTDI,
    input  logic              JSHIFT,
    input  logic              JUPDATE,
    input  logic              JCE2,
    output logic              JTD2,
    output logic              bus_we,
    output logic              bus_re,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata
);

    localparam int unsigned SHIFT_W = DATA_W + ADDR_W + 1;
    localparam int unsigned CNT_W   = $clog2(SHIFT_W + 2);

    localparam logic [CNT_W-1:0]  CntFull   = CNT_W'(SHIFT_W);
    localparam logic [CNT_W-1:0]  CntSat    = CNT_W'(SHIFT_W + 1);
    localparam logic [ADDR_W:0]   NumRegsW  = (ADDR_W + 1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0] LastRegA  = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StExec
    } state_e;

    state_e              state;
    logic [SHIFT_W-1:0]  shift_reg;
    logic [CNT_W-1:0]    bit_cnt;
    logic                cmd;        // rw of the operation in EXEC
    logic [DATA_W-1:0]   rd_hold;
    logic [ADDR_W-1:0]   last_addr;
    logic                err;

    // Frame decode from the pre-edge shift register
    logic                frame_rw;
    logic [ADDR_W-1:0]   frame_addr;
    logic [DATA_W-1:0]   frame_data;
    logic [ADDR_W-1:0]   eff_addr;
    logic                addr_ok;
    logic                capture;
    logic                shift;
    logic                upd_live;
    logic                upd_ok;
    logic                set_err;

    assign frame_rw   = shift_reg[0];
    assign frame_addr = shift_reg[ADDR_W:1];
    assign frame_data = shift_reg[SHIFT_W-1:ADDR_W+1];

    always_comb begin
        eff_addr = frame_addr;
`ifdef JTAG_AUTOINC_EN
        if (frame_addr == '1) begin
            eff_addr = (last_addr == LastRegA) ? '0 : last_addr + 1'b1;
        end
`endif
    end

    assign addr_ok  = ({1'b0, eff_addr} < NumRegsW);
    assign capture  = JCE2 & ~JSHIFT;
    assign shift    = JCE2 & JSHIFT;
    // An update that arrives while EXEC is in progress is dropped and flagged.
    assign upd_live = JUPDATE && (state != StExec);
    assign upd_ok   = upd_live && (bit_cnt == CntFull) && addr_ok;
    assign set_err  = (JUPDATE && (state == StExec)) || (upd_live && !upd_ok);

    assign JTD2 = shift_reg[0];

    always_ff @(posedge JTCK or negedge JRSTN) begin
        if (!JRSTN) begin
            state     <= StIdle;
            shift_reg <= '0;
            bit_cnt   <= '0;
            cmd       <= 1'b0;
            rd_hold   <= '0;
            last_addr <= '0;
            err       <= 1'b0;
            bus_we    <= 1'b0;
            bus_re    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else begin
            bus_we <= 1'b0;
            bus_re <= 1'b0;

            // End of the EXEC cycle: commit the result of the bus operation.
            if (state == StExec) begin
                last_addr <= bus_addr;
                if (!cmd) begin
                    rd_hold <= bus_rdata;
                end
            end

            if (capture) begin
                shift_reg <= {rd_hold, last_addr, err};
                bit_cnt   <= '0;
            end else if (shift) begin
                shift_reg <= {JTDI, shift_reg[SHIFT_W-1:1]};
                if (bit_cnt != CntSat) begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end

            // Capture clears err (read-to-clear); a new error on the same edge wins.
            err <= (err & ~capture) | set_err;

            if (upd_ok) begin
                bus_addr  <= eff_addr;
                bus_wdata <= frame_data;
                cmd       <= frame_rw;
                bus_we    <= frame_rw;
                bus_re    <= ~frame_rw;
                state     <= StExec;
            end else if (capture) begin
                state <= StScan;
            end else if ((state == StExec) || upd_live) begin
                state <= StIdle;
            end
        end
    end

endmodule
